// File: rtl/mvb_tx_sequencer_pkg.sv
// Shared types and constants for the MVB transmit path: FSM states,
// bit-source multiplexer select codes and the data length decoder.
package mvb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SDELIM = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC    = 3'd4,
    ST_EDELIM = 3'd5,
    ST_DONE   = 3'd6
  } mvb_state_e;

  localparam logic [1:0] SEL_OFF   = 2'b00;
  localparam logic [1:0] SEL_DELIM = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_CRC   = 2'b11;

  localparam int unsigned LEN_W      = 9;
  localparam logic [8:0]  MASTER_LEN = 9'd16;

  // Unused codes fall back to the shortest frame rather than erroring.
  function automatic logic [8:0] mvb_len_decode(input logic [2:0] len_code);
    logic [8:0] len;
    case (len_code)
      3'b000:  len = 9'd16;
      3'b001:  len = 9'd32;
      3'b010:  len = 9'd64;
      3'b011:  len = 9'd128;
      3'b100:  len = 9'd256;
      default: len = 9'd16;
    endcase
    return len;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mvb_tx_sequencer_if.sv
// Control bus from the frame sequencer to the bit-source mux,
// delimiter generator, data shifter and CRC unit.
interface mvb_tx_sequencer_if;
  logic [1:0] sel;
  logic       multi_en;
  logic       delim_start;
  logic       delim_end;
  logic       delim_type;
  logic       data_load;
  logic       data_shift;
  logic       crc_clr;
  logic       crc_calc;
  logic       crc_shift;

  modport master (
    output sel, multi_en, delim_start, delim_end, delim_type,
           data_load, data_shift, crc_clr, crc_calc, crc_shift
  );

  modport slave (
    input sel, multi_en, delim_start, delim_end, delim_type,
          data_load, data_shift, crc_clr, crc_calc, crc_shift
  );
endinterface

// File: rtl/mvb_tx_sequencer.sv
// MVB frame transmit sequencer: start delimiter, data groups each followed
// by a check sequence, end delimiter. Advances only on bit_tick.
module mvb_tx_sequencer
  import mvb_pkg::*;
#(
  parameter int SDELIM_BITS = 9,
  parameter int EDELIM_BITS = 2,
  parameter int GROUP_BITS  = 64,
  parameter int CRC_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_tick,
  input  logic                tx_req,
  input  logic                frame_type,
  input  logic [2:0]          len_code,
  input  logic                tx_abort,
  output logic                tx_busy,
  output logic                tx_done,
  mvb_tx_sequencer_if.master  ctl
);

  localparam int MAX_BITS = max_int(max_int(SDELIM_BITS, GROUP_BITS),
                                    max_int(CRC_BITS, EDELIM_BITS));
  localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  mvb_state_e       state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [LEN_W-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       sel_q;
  logic             multi_en_q;
  logic             delim_start_q;
  logic             delim_end_q;
  logic             delim_type_q;
  logic             data_load_q;
  logic             data_shift_q;
  logic             crc_clr_q;
  logic             crc_calc_q;
  logic             crc_shift_q;

  logic [CNT_W-1:0] grp_cnt_d;
  logic             cnt_zero;

  // Length of the next data group minus one: full group or whatever is left.
  always_comb begin
    grp_cnt_d = CNT_W'(GROUP_BITS - 1);
    if (remaining_q < LEN_W'(GROUP_BITS)) begin
      grp_cnt_d = CNT_W'(remaining_q - 9'd1);
    end
  end

  assign cnt_zero = (bit_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sel_q         <= SEL_OFF;
      multi_en_q    <= 1'b0;
      delim_start_q <= 1'b0;
      delim_end_q   <= 1'b0;
      delim_type_q  <= 1'b0;
      data_load_q   <= 1'b0;
      data_shift_q  <= 1'b0;
      crc_clr_q     <= 1'b0;
      crc_calc_q    <= 1'b0;
      crc_shift_q   <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      delim_start_q <= 1'b0;
      data_load_q   <= 1'b0;
      data_shift_q  <= 1'b0;
      crc_clr_q     <= 1'b0;
      crc_calc_q    <= 1'b0;
      crc_shift_q   <= 1'b0;

      // Abort wins over any tick and drops the frame without tx_done.
      if (tx_abort && (state_q != ST_IDLE)) begin
        state_q    <= ST_IDLE;
        sel_q      <= SEL_OFF;
        multi_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (tx_req) begin
              delim_type_q <= frame_type;
              remaining_q  <= frame_type ? mvb_len_decode(len_code) : MASTER_LEN;
              busy_q       <= 1'b1;
              state_q      <= ST_ARM;
            end
          end

          ST_ARM: begin
            if (bit_tick) begin
              state_q       <= ST_SDELIM;
              sel_q         <= SEL_DELIM;
              multi_en_q    <= 1'b1;
              delim_start_q <= 1'b1;
              delim_end_q   <= 1'b0;
              bit_cnt_q     <= CNT_W'(SDELIM_BITS - 1);
            end
          end

          ST_SDELIM: begin
            if (bit_tick) begin
              if (cnt_zero) begin
                state_q     <= ST_DATA;
                sel_q       <= SEL_DATA;
                data_load_q <= 1'b1;
                crc_clr_q   <= 1'b1;
                bit_cnt_q   <= grp_cnt_d;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (bit_tick) begin
              crc_calc_q   <= 1'b1;
              data_shift_q <= 1'b1;
              remaining_q  <= remaining_q - 9'd1;
              if (cnt_zero) begin
                state_q   <= ST_CRC;
                sel_q     <= SEL_CRC;
                bit_cnt_q <= CNT_W'(CRC_BITS - 1);
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end

          ST_CRC: begin
            if (bit_tick) begin
              crc_shift_q <= 1'b1;
              if (cnt_zero) begin
                // The shifter keeps its position across groups; only the CRC restarts.
                if (remaining_q != '0) begin
                  state_q   <= ST_DATA;
                  sel_q     <= SEL_DATA;
                  crc_clr_q <= 1'b1;
                  bit_cnt_q <= grp_cnt_d;
                end else begin
                  state_q       <= ST_EDELIM;
                  sel_q         <= SEL_DELIM;
                  delim_start_q <= 1'b1;
                  delim_end_q   <= 1'b1;
                  bit_cnt_q     <= CNT_W'(EDELIM_BITS - 1);
                end
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end

          ST_EDELIM: begin
            if (bit_tick) begin
              if (cnt_zero) begin
                state_q    <= ST_DONE;
                sel_q      <= SEL_OFF;
                multi_en_q <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end

          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end

          default: begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_OFF;
            multi_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_busy         = busy_q;
  assign tx_done         = done_q;
  assign ctl.sel         = sel_q;
  assign ctl.multi_en    = multi_en_q;
  assign ctl.delim_start = delim_start_q;
  assign ctl.delim_end   = delim_end_q;
  assign ctl.delim_type  = delim_type_q;
  assign ctl.data_load   = data_load_q;
  assign ctl.data_shift  = data_shift_q;
  assign ctl.crc_clr     = crc_clr_q;
  assign ctl.crc_calc    = crc_calc_q;
  assign ctl.crc_shift   = crc_shift_q;

endmodule

// File: tb/tb_mvb_tx_sequencer.sv
// Scoreboard bench for mvb_tx_sequencer: directed frames push expected
// per-frame tallies; a monitor pops and compares when each frame ends.
module tb_mvb_tx_sequencer;
  import mvb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_tick;
  logic       tx_req;
  logic       frame_type;
  logic [2:0] len_code;
  logic       tx_abort;
  logic       tx_busy;
  logic       tx_done;

  mvb_tx_sequencer_if ctl();

  mvb_tx_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_tick   (bit_tick),
    .tx_req     (tx_req),
    .frame_type (frame_type),
    .len_code   (len_code),
    .tx_abort   (tx_abort),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .ctl        (ctl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    aborted;
    int    ticks;
    int    dshift;
    int    ccalc;
    int    dload;
    int    cshift;
    int    cclr;
    int    dstart;
    int    dtype;
    string runs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [12:0] all_out;
  logic [6:0]  strobes;
  assign all_out = {tx_busy, tx_done, ctl.sel, ctl.multi_en, ctl.delim_start, ctl.delim_end,
                    ctl.delim_type, ctl.data_load, ctl.data_shift, ctl.crc_clr,
                    ctl.crc_calc, ctl.crc_shift};
  assign strobes = {tx_done, ctl.delim_start, ctl.data_load, ctl.data_shift,
                    ctl.crc_clr, ctl.crc_calc, ctl.crc_shift};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
  endtask

  function automatic exp_t mk(input bit ab, input int tk, input int ds, input int dl,
                              input int cs, input int cc, input int dst, input int dt,
                              input string runs);
    exp_t e;
    e.aborted = ab; e.ticks = tk; e.dshift = ds; e.ccalc = ds; e.dload = dl;
    e.cshift = cs; e.cclr = cc; e.dstart = dst; e.dtype = dt; e.runs = runs;
    return e;
  endfunction

  // Monitor: tallies strobes and sel run-lengths per frame, compares on busy fall.
  int    m_ticks, m_dshift, m_ccalc, m_dload, m_cshift, m_cclr, m_dstart;
  int    cur_sel, cur_len;
  string m_runs;
  bit    m_done, busy_prev;

  initial begin
    exp_t e;
    busy_prev = 1'b0;
    m_done = 1'b0; cur_len = 0; cur_sel = 0; m_runs = "";
    m_ticks = 0; m_dshift = 0; m_ccalc = 0; m_dload = 0; m_cshift = 0; m_cclr = 0; m_dstart = 0;
    forever begin
      @(negedge clk);
      if (tx_busy === 1'b1 && !busy_prev) begin
        m_ticks = 0; m_dshift = 0; m_ccalc = 0; m_dload = 0; m_cshift = 0;
        m_cclr = 0; m_dstart = 0; m_done = 1'b0; cur_len = 0; m_runs = "";
      end
      if (ctl.data_shift)  m_dshift++;
      if (ctl.crc_calc)    m_ccalc++;
      if (ctl.data_load)   m_dload++;
      if (ctl.crc_shift)   m_cshift++;
      if (ctl.crc_clr)     m_cclr++;
      if (ctl.delim_start) m_dstart++;
      if (tx_done)         m_done = 1'b1;
      if (bit_tick && ctl.multi_en && !tx_abort && !rst) begin
        m_ticks++;
        if (cur_len > 0 && int'(ctl.sel) == cur_sel) cur_len++;
        else begin
          if (cur_len > 0) m_runs = {m_runs, $sformatf("%0d:%0d ", cur_sel, cur_len)};
          cur_sel = int'(ctl.sel);
          cur_len = 1;
        end
      end
      if (tx_busy === 1'b0 && busy_prev) begin
        if (cur_len > 0) m_runs = {m_runs, $sformatf("%0d:%0d ", cur_sel, cur_len)};
        cur_len = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: got unexpected frame end, required none");
        end else begin
          e = exp_q.pop_front();
          chk("ticks", m_ticks, e.ticks);
          chk_str("sel_runs", m_runs, e.runs);
          chk("data_shift", m_dshift, e.dshift);
          chk("crc_calc", m_ccalc, e.ccalc);
          chk("data_load", m_dload, e.dload);
          chk("crc_shift", m_cshift, e.cshift);
          chk("crc_clr", m_cclr, e.cclr);
          chk("delim_start", m_dstart, e.dstart);
          chk("delim_type", int'(ctl.delim_type), e.dtype);
          chk("tx_done_seen", int'(m_done), int'(!e.aborted));
          chk("end_outputs", int'({ctl.sel, ctl.multi_en, strobes}), 0);
        end
      end
      busy_prev = (tx_busy === 1'b1);
    end
  end

  task automatic start_frame(input logic ft, input logic [2:0] lc);
    frame_type = ft; len_code = lc; tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    chk("busy_after_req", int'(tx_busy), 1);
  endtask

  // n ticks, one every `period` cycles; noise raises a conflicting tx_req in the gaps.
  task automatic ticks(input int n, input int period, input bit noise);
    for (int i = 0; i < n; i++) begin
      bit_tick = 1'b1; tx_req = 1'b0;
      @(posedge clk); #1;
      bit_tick = 1'b0;
      for (int j = 1; j < period; j++) begin
        tx_req = noise && (i < n - 1);
        if (noise) begin frame_type = 1'b1; len_code = 3'b100; end
        @(posedge clk); #1;
      end
      tx_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && tx_busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", int'(tx_busy), 0);
  endtask

  initial begin
    int err;
    rst = 1'b1; bit_tick = 1'b0; tx_req = 1'b0; frame_type = 1'b0;
    len_code = 3'b000; tx_abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", int'(all_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ticks while idle must not start anything.
    err = 0;
    for (int i = 0; i < 5; i++) begin
      bit_tick = 1'b1;
      @(posedge clk); #1;
      if (all_out != '0) err++;
    end
    bit_tick = 1'b0;
    chk("idle_tick_no_effect", err, 0);

    // Master frame, length code ignored, with conflicting tx_req pulses mid-frame.
    exp_q.push_back(mk(0, 35, 16, 1, 8, 1, 2, 0, "1:9 2:16 3:8 1:2 "));
    start_frame(1'b0, 3'b011);
    ticks(36, 4, 1'b1);
    wait_idle();
    chk("busy_req_ignored", int'(tx_busy), 0);

    exp_q.push_back(mk(0, 299, 256, 1, 32, 4, 2, 1,
      "1:9 2:64 3:8 2:64 3:8 2:64 3:8 2:64 3:8 1:2 "));
    start_frame(1'b1, 3'b100);
    ticks(300, 1, 1'b0);
    wait_idle();

    exp_q.push_back(mk(0, 51, 32, 1, 8, 1, 2, 1, "1:9 2:32 3:8 1:2 "));
    start_frame(1'b1, 3'b001);
    ticks(52, 2, 1'b0);
    wait_idle();

    // Reserved length code decodes to 16 bits.
    exp_q.push_back(mk(0, 35, 16, 1, 8, 1, 2, 1, "1:9 2:16 3:8 1:2 "));
    start_frame(1'b1, 3'b111);
    ticks(36, 3, 1'b0);
    wait_idle();

    // Abort during the 3rd DATA bit, together with a tick.
    exp_q.push_back(mk(1, 11, 2, 1, 0, 1, 1, 0, "1:9 2:2 "));
    start_frame(1'b0, 3'b011);
    ticks(12, 4, 1'b0);
    tx_abort = 1'b1; bit_tick = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0; bit_tick = 1'b0;
    chk("abort_sel", int'(ctl.sel), 0);
    chk("abort_multi_en", int'(ctl.multi_en), 0);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_done", int'(tx_done), 0);
    @(posedge clk); #1;

    exp_q.push_back(mk(0, 35, 16, 1, 8, 1, 2, 0, "1:9 2:16 3:8 1:2 "));
    start_frame(1'b0, 3'b000);
    ticks(36, 1, 1'b0);
    wait_idle();

    // Reset in the 4th CRC bit of a slave frame, with tx_req held during reset.
    exp_q.push_back(mk(1, 44, 32, 1, 3, 1, 1, 0, "1:9 2:32 3:3 "));
    start_frame(1'b1, 3'b001);
    ticks(45, 1, 1'b0);
    rst = 1'b1; tx_req = 1'b1; frame_type = 1'b1; len_code = 3'b100;
    @(posedge clk); #1;
    chk("rst_mid_crc_outputs", int'(all_out), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; tx_req = 1'b0;
    @(posedge clk); #1;
    chk("req_during_rst_ignored", int'(tx_busy), 0);

    repeat (5) @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mvb_tx_sequencer.md
# mvb_tx_sequencer

Frame-level transmit controller for the MVB encoder path. Sequences one MVB frame as start delimiter → data groups, each followed by an 8-bit check sequence → end delimiter. It drives the bit-source multiplexer select/enable and the strobes of the delimiter generator, data shifter and CRC unit. All sequencing advances on a one-cycle `bit_tick` from the bit-rate divider.

## Interface
Parameters:
- `SDELIM_BITS`, default 9: start-delimiter length in bit times.
- `EDELIM_BITS`, default 2: end-delimiter length in bit times.
- `GROUP_BITS`, default 64: maximum data bits per check group.
- `CRC_BITS`, default 8: check-sequence length in bit times.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `bit_tick` in 1: one-cycle pulse per bit time.
- `tx_req` in 1: frame request, sampled in IDLE only.
- `frame_type` in 1: 0 = master, 1 = slave; latched with `tx_req`.
- `len_code` in 3: data length, latched with `tx_req`. Codes 000 = 16, 001 = 32, 010 = 64, 011 = 128, 100 = 256 bits; 101–111 are treated as 16. Master frames always use 16 bits, whatever the code.
- `tx_abort` in 1: terminate the frame immediately.
- `tx_busy` out 1: high from request accept until return to IDLE.
- `tx_done` out 1: one-cycle pulse after a normal frame completes.
- `sel` out 2: multiplexer select. 00 = off, 01 = delimiter, 10 = data, 11 = CRC.
- `multi_en` out 1: multiplexer enable.
- `delim_start` out 1: one-cycle pulse at the start of a delimiter.
- `delim_end` out 1: level, 0 = start delimiter, 1 = end delimiter.
- `delim_type` out 1: latched `frame_type`.
- `data_load` out 1: one-cycle pulse, load the data shifter.
- `data_shift` out 1: one-cycle pulse, advance the data shifter one bit.
- `crc_clr` out 1: one-cycle pulse, clear the CRC accumulator.
- `crc_calc` out 1: one-cycle pulse, accumulate the current data bit.
- `crc_shift` out 1: one-cycle pulse, advance the CRC output bit.

## Operation
States: IDLE, ARM, SDELIM, DATA, CRC, EDELIM, DONE.

- **IDLE**
  - `tx_req`=1 → latch `frame_type` and `len_code`, set `tx_busy`=1, go to ARM.
  - `bit_tick` is ignored in this state.
- **ARM**
  - On `bit_tick` → go to SDELIM.
  - Assert `delim_start` with `delim_end`=0.
  - Load `bit_cnt` = `SDELIM_BITS`-1.
- **SDELIM**
  - Each `bit_tick` decrements `bit_cnt`.
  - On the tick with `bit_cnt`=0 → go to DATA.
  - Assert `data_load` and `crc_clr`.
  - Load `bit_cnt` = min(remaining, `GROUP_BITS`)-1, where remaining = decoded length.
- **DATA**
  - Each `bit_tick` pulses `crc_calc` and `data_shift`, decrements `bit_cnt` and decrements `remaining`.
  - On the tick with `bit_cnt`=0 → go to CRC and load `bit_cnt` = `CRC_BITS`-1.
- **CRC**
  - Each `bit_tick` pulses `crc_shift`.
  - On the tick with `bit_cnt`=0 and remaining > 0 → go to DATA, pulse `crc_clr`, reload `bit_cnt`. Do not pulse `data_load`; the shifter continues.
  - On the tick with `bit_cnt`=0 and remaining = 0 → go to EDELIM, pulse `delim_start` with `delim_end`=1, load `bit_cnt` = `EDELIM_BITS`-1.
- **EDELIM**
  - Count `EDELIM_BITS` ticks, then go to DONE.
- **DONE**
  - Pulse `tx_done` for one cycle, clear `tx_busy`, go to IDLE.

Output levels per state:
- `sel`: 01 in SDELIM and EDELIM, 10 in DATA, 11 in CRC, 00 elsewhere.
- `multi_en`: 1 in SDELIM, DATA, CRC and EDELIM; 0 elsewhere.

Resulting frame lengths:
- Master frame: 9 + 16 + 8 + 2 = 35 bit times.
- Slave 256-bit frame: 9 + 4×(64+8) + 2 = 299 bit times.

Abort and reset:
- `tx_abort` in any non-IDLE state → IDLE on the next cycle. `sel`=00, `multi_en`=0, `tx_busy`=0, no `tx_done`, all strobes low.
- `tx_abort` takes priority over a simultaneous `bit_tick`.
- `tx_req` while busy is ignored and not queued.
- `tx_req` asserted in the DONE cycle is ignored; it is seen in IDLE if still high.

Counter widths:
- `bit_cnt`: $clog2 of max(`SDELIM_BITS`, `GROUP_BITS`, `CRC_BITS`, `EDELIM_BITS`).
- `remaining`: 9 bits, to hold 256.

## Timing
- All outputs are registered.
- Reset (`rst`=1 at a clock edge) → IDLE. Every output is 0: `sel`=00, `multi_en`=0, `tx_busy`=0, `tx_done`=0, all strobes 0, `delim_end`=0, `delim_type`=0. This also applies mid-frame.
- `tx_req` at edge N → `tx_busy`=1 after edge N.
- First `bit_tick` after that, at edge T → after edge T: `sel`=01, `multi_en`=1, `delim_start`=1 for one cycle.
- State and `sel` change only on the clock edge that samples `bit_tick` (the abort path is the exception).
- Strobes are high for exactly one cycle, immediately after the edge that sampled the tick.
- `tx_done` is high in the cycle after the final EDELIM tick. IDLE is reached one cycle later.
- Back-to-back `bit_tick` on consecutive cycles must be supported; the minimum tick period is 1 cycle.

## Structure
- Shared package `mvb_pkg` holds:
  - the state enum;
  - `sel` constants `SEL_OFF`/`SEL_DELIM`/`SEL_DATA`/`SEL_CRC` (00/01/10/11), also used by the multiplexer;
  - the function `mvb_len_decode(len_code)` returning the bit count.
- No sub-module. The FSM, `bit_cnt` and `remaining` are inline in one module of roughly 200 lines.

## Test plan
- **Master frame**: `frame_type`=0, `len_code`=011, tick every 4 cycles.
  - Expect 35 ticks with `sel` sequence 01×9, 10×16, 11×8, 01×2.
  - Expect 16 `data_shift`, 8 `crc_shift`, 1 `crc_clr`, 2 `delim_start`, then `tx_done`.
- **Slave 256-bit frame**: `len_code`=100, tick every cycle.
  - Expect 4 DATA/CRC groups of 64/8, 4 `crc_clr`, 1 `data_load`, 299 ticks total, `delim_type`=1.
- **Slave 32-bit frame**:
  - Expect one group: 32 `data_shift`, 8 `crc_shift`, 51 ticks total.
- **Abort in the 3rd DATA bit of a master frame**:
  - Next cycle: `sel`=00, `multi_en`=0, `tx_busy`=0, no `tx_done`.
  - A new `tx_req` is accepted afterwards.
- **`rst` asserted mid-CRC**:
  - All outputs 0 after the edge.
  - `tx_req` during `rst` is ignored.
- **`tx_req` while busy, and `bit_tick` while IDLE**:
  - No effect on the frame in progress, no state change, all strobes remain 0.
